line_fill_memory: RTL and testbench
===================================

Name: line_fill_memory

Overview:
- Backing data memory and refill controller directly downstream of the direct-mapped data cache.
- Serves cache line fills on a miss: 4 words of 16 bits each, returned one word per beat with a fixed inter-word wait.
- Also accepts single-word write-through stores from the processor.
- Holds the word array and sequences burst reads so the cache sees a clean valid/done handshake instead of free-running counters.

Parameters:
- ADDR_W, 16, byte-less word address width from the cache.
- DATA_W, 16, word width.
- DEPTH_W, 10, log2 of stored words; address bits above DEPTH_W-1 are ignored (aliasing).
- WAIT_CYCLES, 3, idle cycles before each beat; must be 1..15.

Ports:
- clk_100  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- fill_req  in  1  line fill request; level, held by the cache until fill_busy is seen high.
- fill_addr  in  ADDR_W  miss address; bits [1:0] ignored, line base = {fill_addr[ADDR_W-1:2], 2'b00}.
- fill_busy  out  1  fill in progress.
- fill_valid  out  1  one-cycle strobe, fill_data valid.
- fill_word  out  2  word index within line for the current beat.
- fill_data  out  DATA_W  returned word.
- fill_done  out  1  one-cycle pulse coincident with the beat for word 3.
- wr_en  in  1  write request; level, held until wr_ack.
- wr_addr  in  ADDR_W  write word address.
- wr_data  in  DATA_W  write data.
- wr_ack  out  1  one-cycle pulse; write committed.

Behaviour:
- Clock and reset: one clock, clk_100. rst is synchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE, beat and wait counters 0. The memory array is not cleared.
- FSM states: IDLE, WAIT, BEAT.
- IDLE:
  - If wr_en: write the array at wr_addr[DEPTH_W-1:0], then pulse wr_ack on the next cycle. Stay in IDLE.
  - Else if fill_req: latch the line base, set the word index to 0, load the wait counter with WAIT_CYCLES, and go to WAIT.
  - The write has priority when both are high in the same cycle; the fill is accepted in the following IDLE cycle.
- fill_busy: registered high from the cycle after acceptance through the fill_done cycle inclusive.
- WAIT:
  - Decrement the counter each cycle.
  - When it reaches 1, issue a synchronous RAM read of line base + word index and go to BEAT.
- BEAT:
  - Assert fill_valid, fill_word = index, fill_data = RAM output.
  - If index == 3: assert fill_done, go to IDLE, fill_busy low next cycle.
  - Otherwise: increment the index, reload WAIT_CYCLES, go to WAIT.
- Timing: with acceptance at edge k, word i beats in cycle k + (i+1)*(WAIT_CYCLES+1). Default: k+4, k+8, k+12, k+16; fill_busy drops at k+17.
- Writes during a fill: wr_en is held off and wr_ack stays 0 until IDLE, so no write ever lands in a line mid-fill.
- fill_req during busy: ignored. The cache must drop the request after fill_done; a request still high in the IDLE cycle after done starts a new fill.
- Addresses: word index addition is on the low 2 bits only, with no carry into the line base. Upper address bits beyond DEPTH_W alias.
- Reset mid-fill: abort immediately. No further fill_valid or fill_done, fill_busy 0 the next cycle. Array contents are preserved.
- Outputs: fill_data holds its last value outside beats; only fill_valid qualifies it.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=0, WAIT=1, BEAT=2).
  - WORDS_PER_LINE=4 and word-index width 2, shared with the cache so both agree on line geometry.
  - Default DATA_W/ADDR_W.
- One sub-module, sync_word_ram: single-port, DATA_W x 2^DEPTH_W, registered read, write-first unused since read and write are never concurrent.

Test Plan:
- Reset check: assert rst 2 cycles -> all outputs 0; fill_req held low -> fill_busy stays 0.
- Basic fill:
  - Write 0x1111,0x2222,0x3333,0x4444 to 0x0F04..0x0F07 (4 wr_ack pulses).
  - Then fill_req with fill_addr=0x0F06 at edge k.
  - Expect fill_valid at k+4/8/12/16 with fill_word 0..3 and data 0x1111..0x4444, fill_done at k+16 only, fill_busy high k+1..k+16.
- Write held during fill:
  - wr_en to 0x0F05 = 0xBEEF raised at k+5.
  - Expect wr_ack no earlier than k+18, beat 1 still returns 0x2222, and a second fill returns 0xBEEF for word 1.
- Simultaneous requests: wr_en and fill_req both high in IDLE -> wr_ack the next cycle, fill accepted one cycle later, first beat 5 cycles after the write-accept edge.
- Reset mid-fill: rst pulsed at k+9 -> no further fill_valid or fill_done, fill_busy 0 at k+10; data written before the reset reads back unchanged on the next fill.
- Aliasing and parameter:
  - Write 0xA5A5 to 0x0400 (DEPTH_W=10); fill 0x0000 -> word 0 = 0xA5A5.
  - Rerun with WAIT_CYCLES=1 -> beats at k+2,4,6,8.

Source files
------------

// File: rtl/line_fill_memory_pkg.sv
// Line geometry and refill FSM encoding shared by the
// refill controller and the cache above it.
package line_fill_memory_pkg;

  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_IDX_W     = 2;
  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_BEAT = 2'd2
  } fill_state_t;

endpackage

// File: rtl/line_fill_memory_sync_word_ram.sv
// Single-port word array with registered read port.
// Read and write never overlap, so no collision logic.
module sync_word_ram #(
  parameter int DATA_W  = 16,
  parameter int DEPTH_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic               re,
  input  logic [DEPTH_W-1:0] addr,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_W];

  // array write; contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // registered read; output only changes on a read
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/line_fill_memory.sv
// Backing store and line refill sequencer below the
// direct-mapped data cache.
module line_fill_memory
  import line_fill_memory_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH_W     = 10,
  parameter int WAIT_CYCLES = 3
) (
  input  logic              clk_100,
  input  logic              rst,
  input  logic              fill_req,
  input  logic [ADDR_W-1:0] fill_addr,
  output logic              fill_busy,
  output logic              fill_valid,
  output logic [1:0]        fill_word,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_done,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack
);

  localparam logic [WORD_IDX_W-1:0] LAST_WORD =
    WORD_IDX_W'(WORDS_PER_LINE - 1);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  fill_state_t               state, state_next;
  logic [3:0]                cnt, cnt_next;
  logic [WORD_IDX_W-1:0]     idx, idx_next;
  logic [DEPTH_W-3:0]        line, line_next;
  logic                      ack, ack_next;
  logic                      ram_we, ram_re;
  logic [DEPTH_W-1:0]        ram_addr;
  logic [DATA_W-1:0]         ram_rdata;
  logic                      unused_addr;

  assign unused_addr = ^{fill_addr[ADDR_W-1:DEPTH_W],
                         fill_addr[1:0],
                         wr_addr[ADDR_W-1:DEPTH_W]};

  // state, counters and latched line tag
  always_ff @(posedge clk_100) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      line  <= '0;
      ack   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      line  <= line_next;
      ack   <= ack_next;
    end
  end

  // next state; writes win over fills, only in IDLE
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    line_next  = line;
    ack_next   = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = wr_addr[DEPTH_W-1:0];
    unique case (state)
      ST_IDLE: begin
        if (wr_en && !ack) begin
          ram_we   = 1'b1;
          ack_next = 1'b1;
        end else if (fill_req) begin
          line_next  = fill_addr[DEPTH_W-1:2];
          idx_next   = '0;
          cnt_next   = WAIT_LOAD;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          ram_re     = 1'b1;
          ram_addr   = {line, idx};
          state_next = ST_BEAT;
        end
      end
      ST_BEAT: begin
        if (idx == LAST_WORD) begin
          state_next = ST_IDLE;
        end else begin
          idx_next   = idx + 1'b1;
          cnt_next   = WAIT_LOAD;
          state_next = ST_WAIT;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  sync_word_ram #(
    .DATA_W  (DATA_W),
    .DEPTH_W (DEPTH_W)
  ) u_ram (
    .clk   (clk_100),
    .rst   (rst),
    .we    (ram_we && !rst),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (wr_data),
    .rdata (ram_rdata)
  );

  assign fill_busy  = (state != ST_IDLE);
  assign fill_valid = (state == ST_BEAT);
  assign fill_done  = fill_valid && (idx == LAST_WORD);
  assign fill_word  = fill_valid ? idx : '0;
  assign fill_data  = ram_rdata;
  assign wr_ack     = ack;

endmodule

// File: tb/tb_line_fill_memory.sv
// Scoreboard bench for line_fill_memory: one instance
// with the default wait, one with a single wait cycle.
module tb_line_fill_memory;

  typedef struct {
    int          cyc;
    logic [1:0]  word;
    logic [15:0] data;
    logic        done;
  } beat_t;

  logic        clk_100 = 1'b0;
  logic        rst = 1'b1;
  logic        fill_req = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] fill_addr = '0;
  logic [15:0] wr_addr = '0;
  logic [15:0] wr_data = '0;

  logic        a_busy, a_valid, a_done, a_ack;
  logic [1:0]  a_word;
  logic [15:0] a_data;
  logic        b_busy, b_valid, b_done, b_ack;
  logic [1:0]  b_word;
  logic [15:0] b_data;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          sel = 0;
  logic [15:0] mem [0:1023];
  beat_t       sbq [$];

  always #5 clk_100 = ~clk_100;

  always @(posedge clk_100) cyc <= cyc + 1;

  line_fill_memory #(
    .ADDR_W(16), .DATA_W(16), .DEPTH_W(10), .WAIT_CYCLES(3)
  ) u_w3 (
    .clk_100(clk_100), .rst(rst),
    .fill_req(fill_req), .fill_addr(fill_addr),
    .fill_busy(a_busy), .fill_valid(a_valid),
    .fill_word(a_word), .fill_data(a_data),
    .fill_done(a_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(a_ack)
  );

  line_fill_memory #(
    .ADDR_W(16), .DATA_W(16), .DEPTH_W(10), .WAIT_CYCLES(1)
  ) u_w1 (
    .clk_100(clk_100), .rst(rst),
    .fill_req(fill_req), .fill_addr(fill_addr),
    .fill_busy(b_busy), .fill_valid(b_valid),
    .fill_word(b_word), .fill_data(b_data),
    .fill_done(b_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(b_ack)
  );

  // beat monitor: pop and compare against the scoreboard
  always @(negedge clk_100) begin
    logic        v, d;
    logic [1:0]  w;
    logic [15:0] x;
    beat_t       e;
    v = (sel != 0) ? b_valid : a_valid;
    d = (sel != 0) ? b_done  : a_done;
    w = (sel != 0) ? b_word  : a_word;
    x = (sel != 0) ? b_data  : a_data;
    if (d && !v) begin
      checks++;
      failures++;
      $display("FAIL done_without_valid cyc=%0d", cyc);
    end
    if (v) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat cyc=%0d word=%0d data=%h",
                 cyc, w, x);
      end else begin
        e = sbq.pop_front();
        if (cyc !== e.cyc || w !== e.word ||
            x !== e.data || d !== e.done) begin
          failures++;
          $display("FAIL beat got cyc=%0d word=%0d data=%h done=%b expected cyc=%0d word=%0d data=%h done=%b",
                   cyc, w, x, d, e.cyc, e.word, e.data, e.done);
        end
      end
    end
  end

  task automatic push_fill(input int k, input logic [15:0] a,
                           input int w, input int n);
    beat_t       e;
    logic [9:0]  idx;
    for (int i = 0; i < n; i++) begin
      idx    = {a[9:2], 2'(i)};
      e.cyc  = k + (i + 1) * (w + 1) - 1;
      e.word = 2'(i);
      e.data = mem[idx];
      e.done = (i == 3);
      sbq.push_back(e);
    end
  endtask

  task automatic start_fill(input logic [15:0] a, input int w,
                            input int n, output int k);
    logic b;
    @(negedge clk_100);
    fill_req  = 1'b1;
    fill_addr = a;
    k = cyc + 1;
    push_fill(k, a, w, n);
    @(negedge clk_100);
    b = (sel != 0) ? b_busy : a_busy;
    checks++;
    if (b !== 1'b1) begin
      failures++;
      $display("FAIL fill_accept_busy got=%b want=1", b);
    end
    fill_req = 1'b0;
  endtask

  task automatic drain(input string name);
    int   n = 0;
    logic b;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk_100);
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL %s missing_beats got=%0d want=0",
               name, sbq.size());
      sbq.delete();
    end
    @(negedge clk_100);
    b = (sel != 0) ? b_busy : a_busy;
    checks++;
    if (b !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_after_done got=%b want=0", name, b);
    end
  endtask

  task automatic do_write(input logic [15:0] a,
                          input logic [15:0] d);
    int n = 0;
    @(negedge clk_100);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    do begin
      @(negedge clk_100);
      n++;
    end while (a_ack !== 1'b1 && n < 100);
    wr_en = 1'b0;
    checks++;
    if (a_ack !== 1'b1) begin
      failures++;
      $display("FAIL write_ack addr=%h got=%b want=1", a, a_ack);
    end else begin
      mem[a[9:0]] = d;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk_100);
    checks++;
    if ({a_busy, a_valid, a_done, a_ack, a_word, a_data}
        !== 22'd0) begin
      failures++;
      $display("FAIL reset_outputs_w3 got=%h want=0",
               {a_busy, a_valid, a_done, a_ack, a_word, a_data});
    end
    checks++;
    if ({b_busy, b_valid, b_done, b_ack, b_word, b_data}
        !== 22'd0) begin
      failures++;
      $display("FAIL reset_outputs_w1 got=%h want=0",
               {b_busy, b_valid, b_done, b_ack, b_word, b_data});
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk_100);
      checks++;
      if (a_busy !== 1'b0) begin
        failures++;
        $display("FAIL idle_busy got=%b want=0", a_busy);
      end
    end
  endtask

  task automatic test_basic_fill();
    int k;
    int low = 0;
    for (int i = 0; i < 4; i++)
      do_write(16'h0F04 + 16'(i), 16'h1111 * 16'(i + 1));
    @(negedge clk_100);
    checks++;
    if (a_ack !== 1'b0) begin
      failures++;
      $display("FAIL ack_pulse_width got=%b want=0", a_ack);
    end
    start_fill(16'h0F06, 3, 4, k);
    repeat (15) begin
      @(negedge clk_100);
      if (a_busy !== 1'b1) low++;
    end
    checks++;
    if (low != 0) begin
      failures++;
      $display("FAIL basic_busy_gaps got=%0d want=0", low);
    end
    drain("basic");
  endtask

  task automatic test_write_held();
    int k;
    int n = 0;
    start_fill(16'h0F04, 3, 4, k);
    while (cyc < k + 4) @(negedge clk_100);
    wr_en   = 1'b1;
    wr_addr = 16'h0F05;
    wr_data = 16'hBEEF;
    do begin
      @(negedge clk_100);
      n++;
    end while (a_ack !== 1'b1 && n < 100);
    wr_en = 1'b0;
    checks++;
    if (a_ack !== 1'b1) begin
      failures++;
      $display("FAIL held_write_ack got=%b want=1", a_ack);
    end else begin
      mem[10'h305] = 16'hBEEF;
      checks++;
      if (cyc - k < 17) begin
        failures++;
        $display("FAIL held_write_early got=%0d want>=17", cyc - k);
      end
    end
    drain("held_first");
    start_fill(16'h0F05, 3, 4, k);
    drain("held_second");
  endtask

  task automatic test_simultaneous();
    int j;
    @(negedge clk_100);
    wr_en     = 1'b1;
    wr_addr   = 16'h0F06;
    wr_data   = 16'h5A5A;
    fill_req  = 1'b1;
    fill_addr = 16'h0F04;
    j = cyc + 1;
    @(negedge clk_100);
    checks++;
    if (a_ack !== 1'b1 || a_busy !== 1'b0) begin
      failures++;
      $display("FAIL simul_write_first got ack=%b busy=%b want ack=1 busy=0",
               a_ack, a_busy);
    end
    wr_en = 1'b0;
    mem[10'h306] = 16'h5A5A;
    push_fill(j + 1, 16'h0F04, 3, 4);
    @(negedge clk_100);
    checks++;
    if (a_busy !== 1'b1) begin
      failures++;
      $display("FAIL simul_fill_accept got=%b want=1", a_busy);
    end
    fill_req = 1'b0;
    drain("simul");
  endtask

  task automatic test_back_to_back();
    int k;
    @(negedge clk_100);
    fill_req  = 1'b1;
    fill_addr = 16'h0F04;
    k = cyc + 1;
    push_fill(k, 16'h0F04, 3, 4);
    push_fill(k + 17, 16'h0F04, 3, 4);
    while (cyc < k + 16) @(negedge clk_100);
    checks++;
    if (a_busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle_gap got=%b want=0", a_busy);
    end
    @(negedge clk_100);
    checks++;
    if (a_busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_restart got=%b want=1", a_busy);
    end
    fill_req = 1'b0;
    drain("b2b");
  endtask

  task automatic test_reset_mid();
    int k;
    int bad = 0;
    start_fill(16'h0F04, 3, 2, k);
    while (cyc < k + 8) @(negedge clk_100);
    rst = 1'b1;
    @(negedge clk_100);
    checks++;
    if (a_busy !== 1'b0 || a_valid !== 1'b0 || a_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort got busy=%b valid=%b done=%b want 0",
               a_busy, a_valid, a_done);
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk_100);
      if (a_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || sbq.size() != 0) begin
      failures++;
      $display("FAIL reset_quiet got busy_cycles=%0d pending=%0d want 0",
               bad, sbq.size());
      sbq.delete();
    end
    start_fill(16'h0F04, 3, 4, k);
    drain("reset_refill");
  endtask

  task automatic test_alias();
    int k;
    do_write(16'h0400, 16'hA5A5);
    do_write(16'h0001, 16'h0101);
    do_write(16'h0002, 16'h0202);
    do_write(16'h0003, 16'h0303);
    start_fill(16'h0000, 3, 4, k);
    drain("alias_base");
    start_fill(16'h8C02, 3, 4, k);
    drain("alias_high");
  endtask

  task automatic test_wait1();
    int k;
    repeat (30) @(negedge clk_100);
    for (int i = 0; i < 4; i++)
      do_write(16'h0F04 + 16'(i), 16'hC0D0 + 16'(i));
    sel = 1;
    start_fill(16'h0F06, 1, 4, k);
    drain("wait1");
    repeat (20) @(negedge clk_100);
    sel = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_fill();
    test_write_held();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_alias();
    test_wait1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
